// File: rtl/alt_vipcti131_frame_write_scheduler.sv
// Frame write scheduler: splits one video frame into bounded write bursts for the
// Avalon-MM bursting master's user interface and ping-pongs between two frame buffers.
module alt_vipcti131_frame_write_scheduler #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 16,
    parameter int BURST_LENGTH_WIDTH = 11,
    parameter int BURST_SIZE         = 32,
    parameter int FRAME_WORDS_WIDTH  = 24,
    parameter int BYTES_PER_WORD     = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          go,
    input  logic [FRAME_WORDS_WIDTH-1:0]  frame_words,
    input  logic [ADDR_WIDTH-1:0]         base_addr_0,
    input  logic [ADDR_WIDTH-1:0]         base_addr_1,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          buf_sel,
    input  logic [DATA_WIDTH-1:0]         din_data,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic                          command,
    output logic                          is_burst,
    output logic                          is_write_not_read,
    output logic [BURST_LENGTH_WIDTH-1:0] burst_length,
    output logic [DATA_WIDTH-1:0]         writedata,
    output logic                          write,
    input  logic                          stall
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

    localparam logic [FRAME_WORDS_WIDTH-1:0]  BURST_MAX = FRAME_WORDS_WIDTH'(BURST_SIZE);
    localparam logic [ADDR_WIDTH-1:0]         BYTES_INC = ADDR_WIDTH'(BYTES_PER_WORD);
    localparam logic [BURST_LENGTH_WIDTH-1:0] ONE_BEAT  = BURST_LENGTH_WIDTH'(1);

    state_e                        state_q, state_d;
    logic [FRAME_WORDS_WIDTH-1:0]  remaining_q, remaining_d;
    logic [BURST_LENGTH_WIDTH-1:0] beats_q, beats_d;
    logic [BURST_LENGTH_WIDTH-1:0] burst_len_q, burst_len_d;
    logic [ADDR_WIDTH-1:0]         cur_addr_q, cur_addr_d;
    logic                          buf_sel_q, buf_sel_d;
    logic                          toggle_q, toggle_d;
    logic                          beat_taken;

    // The remainder never exceeds BURST_MAX after clipping, so the narrowing cast is lossless.
    function automatic logic [BURST_LENGTH_WIDTH-1:0] clip_burst(
        input logic [FRAME_WORDS_WIDTH-1:0] words
    );
        return (words < BURST_MAX) ? BURST_LENGTH_WIDTH'(words)
                                   : BURST_LENGTH_WIDTH'(BURST_SIZE);
    endfunction

    assign beat_taken = (state_q == DATA) && din_valid && !stall;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            beats_q     <= '0;
            burst_len_q <= '0;
            cur_addr_q  <= '0;
            buf_sel_q   <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            burst_len_q <= burst_len_d;
            cur_addr_q  <= cur_addr_d;
            buf_sel_q   <= buf_sel_d;
            toggle_q    <= toggle_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        burst_len_d = burst_len_q;
        cur_addr_d  = cur_addr_q;
        buf_sel_d   = buf_sel_q;
        toggle_d    = toggle_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    if (frame_words != '0) begin
                        remaining_d = frame_words;
                        cur_addr_d  = buf_sel_q ? base_addr_1 : base_addr_0;
                        burst_len_d = clip_burst(frame_words);
                        toggle_d    = 1'b1;
                        state_d     = CMD;
                    end else begin
                        // Empty frame: report completion but keep the current buffer.
                        toggle_d = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            CMD: begin
                if (!stall) begin
                    beats_d     = burst_len_q;
                    remaining_d = remaining_q - FRAME_WORDS_WIDTH'(burst_len_q);
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (beat_taken) begin
                    beats_d = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        cur_addr_d = cur_addr_q + ADDR_WIDTH'(burst_len_q) * BYTES_INC;
                        if (remaining_q != '0) begin
                            burst_len_d = clip_burst(remaining_q);
                            state_d     = CMD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (toggle_q) buf_sel_d = !buf_sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        command    = (state_q == CMD);
        write      = (state_q == DATA) && din_valid;
        din_ready  = (state_q == DATA) && !stall;
        frame_done = (state_q == DONE);
    end

    assign busy              = (state_q != IDLE);
    assign buf_sel           = buf_sel_q;
    assign addr              = cur_addr_q;
    assign burst_length      = burst_len_q;
    assign is_burst          = 1'b1;
    assign is_write_not_read = 1'b1;
    assign writedata         = din_data;

endmodule

// File: tb/tb_alt_vipcti131_frame_write_scheduler.sv
// Randomized bench for the frame write scheduler: a frame-level model of the burst
// split and pixel order is compared against the commands and writes the master sees.
module tb_alt_vipcti131_frame_write_scheduler;

    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int BLW = 11;
    localparam int BS  = 32;
    localparam int FWW = 24;
    localparam int BPW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           go = 1'b0;
    logic [FWW-1:0] frame_words = '0;
    logic [AW-1:0]  base_addr_0 = 32'h0000_1000;
    logic [AW-1:0]  base_addr_1 = 32'h0008_0000;
    logic           busy, frame_done, buf_sel;
    logic [DW-1:0]  din_data = '0;
    logic           din_valid = 1'b0;
    logic           din_ready;
    logic [AW-1:0]  addr;
    logic           command, is_burst, is_write_not_read, write;
    logic [BLW-1:0] burst_length;
    logic [DW-1:0]  writedata;
    logic           stall = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;
    logic model_buf = 1'b0;

    alt_vipcti131_frame_write_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH_WIDTH(BLW),
        .BURST_SIZE(BS), .FRAME_WORDS_WIDTH(FWW), .BYTES_PER_WORD(BPW)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .frame_words(frame_words),
        .base_addr_0(base_addr_0), .base_addr_1(base_addr_1),
        .busy(busy), .frame_done(frame_done), .buf_sel(buf_sel),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .addr(addr), .command(command), .is_burst(is_burst),
        .is_write_not_read(is_write_not_read), .burst_length(burst_length),
        .writedata(writedata), .write(write), .stall(stall)
    );

    always #5 clock = ~clock;

    // One frame: valid_pct < 0 makes din_valid alternate 1,0,1,0 each cycle.
    task automatic run_frame(input int fw, input int stall_pct, input int valid_pct,
                             input int cmd_hold, input bit go_mid, input string name);
        logic [AW-1:0]  exp_addr[$];
        int             exp_len[$];
        logic [AW-1:0]  got_addr[$];
        int             got_len[$];
        int             got_beats[$];
        logic [DW-1:0]  pix[$];
        logic [DW-1:0]  got_data[$];
        logic [AW-1:0]  a;
        logic [AW-1:0]  prev_addr = '0;
        logic [BLW-1:0] prev_len = '0;
        logic           prev_cs = 1'b0;
        int rem, pix_idx = 0, k = 0, budget, n_cmp, bad;
        int first_cmd_k = -1, last_wr_k = -1, done_k = -1, viol = 0, hold_bad = 0;

        a   = model_buf ? base_addr_1 : base_addr_0;
        rem = fw;
        while (rem > 0) begin
            int l = (rem < BS) ? rem : BS;
            exp_addr.push_back(a);
            exp_len.push_back(l);
            a   = a + AW'(l * BPW);
            rem = rem - l;
        end
        for (int i = 0; i < fw; i++) pix.push_back(DW'($urandom));
        budget = 20 * fw + 50;

        @(posedge clock); #1;
        go = 1'b1; frame_words = FWW'(fw); stall = 1'b0; din_valid = 1'b0;
        @(posedge clock); #1;
        go = 1'b0; frame_words = FWW'($urandom);

        while (done_k < 0 && k < budget) begin
            if (k > 0) begin @(posedge clock); #1; end
            stall = (k < cmd_hold) ? 1'b1 : ($urandom_range(99) < stall_pct);
            if (valid_pct < 0) din_valid = (k % 2 == 0);
            else               din_valid = ($urandom_range(99) < valid_pct);
            din_data = (pix_idx < fw) ? pix[pix_idx] : DW'($urandom);
            go = go_mid && (k == 3);
            if (go) frame_words = FWW'($urandom_range(500, 1));
            @(negedge clock);
            if (din_ready && stall) viol++;
            if (din_ready && (write !== din_valid)) viol++;
            if (command && (write || din_ready)) viol++;
            if (writedata !== din_data) viol++;
            if (is_burst !== 1'b1 || is_write_not_read !== 1'b1 || busy !== 1'b1) viol++;
            if (prev_cs && (command !== 1'b1 || addr !== prev_addr || burst_length !== prev_len))
                hold_bad++;
            prev_cs   = command && stall;
            prev_addr = addr;
            prev_len  = burst_length;
            if (command && !stall) begin
                got_addr.push_back(addr);
                got_len.push_back(int'(burst_length));
                got_beats.push_back(0);
                if (first_cmd_k < 0) first_cmd_k = k;
            end
            if (write && !stall) begin
                got_data.push_back(writedata);
                if (got_beats.size() > 0) got_beats[got_beats.size()-1]++;
                last_wr_k = k;
            end
            if (din_valid && din_ready) pix_idx++;
            if (frame_done === 1'b1) done_k = k;
            k++;
        end
        go = 1'b0;

        n_checks++;
        if (done_k < 0) begin
            n_fail++;
            $display("FAIL %s timeout: no frame_done within %0d cycles", name, budget);
        end
        n_checks++;
        if (got_addr.size() !== exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s cmd_count: got %0d expected %0d", name, got_addr.size(), exp_addr.size());
        end
        n_cmp = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n_cmp; i++) begin
            n_checks++;
            if (got_addr[i] !== exp_addr[i] || got_len[i] !== exp_len[i] || got_beats[i] !== exp_len[i]) begin
                n_fail++;
                $display("FAIL %s burst%0d: got addr %h len %0d beats %0d expected addr %h len %0d",
                         name, i, got_addr[i], got_len[i], got_beats[i], exp_addr[i], exp_len[i]);
            end
        end
        bad = 0;
        for (int i = 0; i < got_data.size() && i < fw; i++) if (got_data[i] !== pix[i]) bad++;
        n_checks++;
        if (got_data.size() !== fw || bad != 0) begin
            n_fail++;
            $display("FAIL %s data: got %0d words (%0d wrong) expected %0d words", name, got_data.size(), bad, fw);
        end
        if (stall_pct == 0) begin
            n_checks++;
            if (first_cmd_k !== ((fw > 0) ? cmd_hold : -1)) begin
                n_fail++;
                $display("FAIL %s cmd_latency: got cycle %0d expected %0d", name, first_cmd_k, (fw > 0) ? cmd_hold : -1);
            end
        end
        n_checks++;
        if (done_k !== ((fw > 0) ? last_wr_k + 1 : 0)) begin
            n_fail++;
            $display("FAIL %s done_latency: got cycle %0d expected %0d", name, done_k, (fw > 0) ? last_wr_k + 1 : 0);
        end
        n_checks++;
        if (viol != 0 || hold_bad != 0) begin
            n_fail++;
            $display("FAIL %s protocol: got %0d violations %0d hold errors expected 0 and 0", name, viol, hold_bad);
        end

        @(posedge clock); #1;
        stall = 1'b0; din_valid = 1'b0;
        @(negedge clock);
        if (fw > 0) model_buf = !model_buf;
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || buf_sel !== model_buf) begin
            n_fail++;
            $display("FAIL %s after_done: got done %b busy %b buf_sel %b expected 0 0 %b",
                     name, frame_done, busy, buf_sel, model_buf);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; go = 1'b1; frame_words = 24'd64; din_valid = 1'b1; stall = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({busy, frame_done, buf_sel, command, write, din_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, frame_done, buf_sel, command, write, din_ready});
        end
        n_checks++;
        if (addr !== '0 || burst_length !== '0) begin
            n_fail++;
            $display("FAIL reset_addr_len: got addr %h len %0d expected 0 0", addr, burst_length);
        end
        go = 1'b0; din_valid = 1'b0;
        reset = 1'b1;
        model_buf = 1'b0;
    endtask

    task automatic test_basic_64();
        run_frame(64, 0, 100, 0, 1'b0, "basic64");
    endtask

    task automatic test_remainder_70();
        run_frame(70, 0, 100, 0, 1'b0, "rem70_buf1");
    endtask

    task automatic test_cmd_stall();
        run_frame(40, 0, 100, 5, 1'b0, "cmd_stall");
    endtask

    task automatic test_valid_toggle();
        run_frame(33, 0, -1, 0, 1'b0, "valid_toggle");
    endtask

    task automatic test_zero_length();
        run_frame(0, 0, 100, 0, 1'b0, "zero_len");
    endtask

    task automatic test_go_while_busy();
        run_frame(100, 20, 80, 0, 1'b1, "go_busy");
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        go = 1'b1; frame_words = 24'd70; stall = 1'b0; din_valid = 1'b1;
        @(posedge clock); #1;
        go = 1'b0;
        repeat (39) @(posedge clock);
        #3;
        n_checks++;
        if (din_ready !== 1'b1 || write !== 1'b1 || buf_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got ready %b write %b buf_sel %b expected 1 1 1", din_ready, write, buf_sel);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, frame_done, buf_sel, command, write, din_ready} !== 6'b0 ||
            addr !== '0 || burst_length !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got flags %b addr %h len %0d expected 000000 0 0",
                     {busy, frame_done, buf_sel, command, write, din_ready}, addr, burst_length);
        end
        model_buf = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1; din_valid = 1'b0;
        run_frame(70, 0, 100, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        base_addr_1 = 32'hFFFF_FFE0;
        for (int i = 0; i < 6; i++)
            run_frame(int'($urandom_range(200, 1)), 30, 70, 0, 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_basic_64();
        test_remainder_70();
        test_cmd_stall();
        test_valid_toggle();
        test_zero_length();
        test_go_while_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
